// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word/opcode types and branch resolver state encoding
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [2:0] lc3b_nzp;
  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;
  typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_BLACKOUT} bru_state_t;
  function automatic logic is_branch(lc3b_opcode op);
    return op inside {op_br, op_jmp, op_jsr, op_trap};
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: increment-only counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (inc && !(&count)) count <= count + WIDTH'(1);
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: MEM-stage branch resolver issuing a one-shot registered redirect
module branch_resolve_unit
  import lc3b_types::*;
#(
  parameter int FLUSH_DEPTH = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  lc3b_opcode           opcode_in,
  input  lc3b_nzp              nzp_in,
  input  lc3b_nzp              cc_in,
  input  lc3b_word             target_in,
  input  logic                 stall,
  output logic                 branch_enable,
  output logic                 unconditional_branch,
  output lc3b_word             redirect_pc,
  output logic [CNT_WIDTH-1:0] br_count,
  output logic [CNT_WIDTH-1:0] br_taken_count
);
  localparam int BW = $clog2(FLUSH_DEPTH);
  bru_state_t state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic be_q, be_d, ub_q, ub_d, accept, taken, hold;
  lc3b_word pc_q, pc_d;
  always_comb begin
    accept  = state_q == S_IDLE && valid_in && !stall && is_branch(opcode_in);
    taken   = accept && (opcode_in != op_br || |(nzp_in & cc_in));
    hold    = state_q == S_REDIRECT && stall;
    be_d    = taken ? opcode_in == op_br : hold && be_q;
    ub_d    = taken ? opcode_in != op_br : hold && ub_q;
    pc_d    = taken ? target_in : pc_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:     state_d = taken ? S_REDIRECT : S_IDLE;
      S_REDIRECT: if (!stall) begin
        state_d = S_BLACKOUT;
        cnt_d   = BW'(FLUSH_DEPTH - 2);
      end
      S_BLACKOUT: if (!stall) begin
        state_d = cnt_q == '0 ? S_IDLE : S_BLACKOUT;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - BW'(1);
      end
      default:    state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      be_q    <= 1'b0;
      ub_q    <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      be_q    <= be_d;
      ub_q    <= ub_d;
      pc_q    <= pc_d;
    end
  assign branch_enable        = be_q;
  assign unconditional_branch = ub_q;
  assign redirect_pc          = pc_q;
  sat_counter #(.WIDTH(CNT_WIDTH)) u_br_cnt (
    .clk(clk), .reset(reset), .inc(accept), .count(br_count)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_taken_cnt (
    .clk(clk), .reset(reset), .inc(taken), .count(br_taken_count)
  );
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: scenario tasks with a queue of expected per-cycle outputs
module tb_branch_resolve_unit;
  import lc3b_types::*;
  typedef struct packed {
    logic        be;
    logic        ub;
    logic [15:0] pc;
    logic [15:0] brc;
    logic [15:0] tc;
  } obs_t;
  typedef struct packed {
    logic        rst;
    logic        v;
    lc3b_opcode  op;
    logic [2:0]  nzp;
    logic [2:0]  cc;
    logic [15:0] tgt;
    logic        st;
    obs_t        e;
  } stim_t;
  logic clk = 1'b0, reset, valid_in, stall;
  lc3b_opcode opcode_in;
  logic [2:0] nzp_in, cc_in;
  logic [15:0] target_in, redirect_pc, redirect_pc4, br_count, br_taken_count;
  logic branch_enable, unconditional_branch, branch_enable4, unconditional_branch4;
  logic [3:0] br_count4, br_taken_count4;
  int checks = 0, failures = 0;
  obs_t exp_q[$];
  always #5 clk = ~clk;
  branch_resolve_unit dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .opcode_in(opcode_in),
    .nzp_in(nzp_in), .cc_in(cc_in), .target_in(target_in), .stall(stall),
    .branch_enable(branch_enable), .unconditional_branch(unconditional_branch),
    .redirect_pc(redirect_pc), .br_count(br_count), .br_taken_count(br_taken_count)
  );
  branch_resolve_unit #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .opcode_in(opcode_in),
    .nzp_in(nzp_in), .cc_in(cc_in), .target_in(target_in), .stall(stall),
    .branch_enable(branch_enable4), .unconditional_branch(unconditional_branch4),
    .redirect_pc(redirect_pc4), .br_count(br_count4), .br_taken_count(br_taken_count4)
  );
  always @(negedge clk)
    if (branch_enable && unconditional_branch) begin
      checks++;
      failures++;
      $display("FAIL invariant both flags set at %0t", $time);
    end
  function automatic stim_t mk(input logic rst, input logic v, input lc3b_opcode op,
      input logic [2:0] nzp, input logic [2:0] cc, input logic [15:0] tgt, input logic st,
      input logic be, input logic ub, input logic [15:0] pc, input logic [15:0] brc,
      input logic [15:0] tc);
    mk = '{rst: rst, v: v, op: op, nzp: nzp, cc: cc, tgt: tgt, st: st,
           e: '{be: be, ub: ub, pc: pc, brc: brc, tc: tc}};
  endfunction
  function automatic obs_t sample(input logic narrow);
    sample = narrow ? '{branch_enable4, unconditional_branch4, redirect_pc4,
                        16'(br_count4), 16'(br_taken_count4)}
                    : '{branch_enable, unconditional_branch, redirect_pc, br_count, br_taken_count};
  endfunction
  function automatic string fmt(input obs_t o);
    return $sformatf("be=%b ub=%b pc=%h br_count=%0d taken=%0d", o.be, o.ub, o.pc, o.brc, o.tc);
  endfunction
  task automatic apply(input stim_t s);
    reset = s.rst; valid_in = s.v; opcode_in = s.op; nzp_in = s.nzp;
    cc_in = s.cc; target_in = s.tgt; stall = s.st;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    apply(mk(1, 0, op_add, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    obs_t o;
    do_reset();
    o = sample(0);
    checks++;
    if (o !== obs_t'(0)) begin failures++; $display("FAIL reset got %s required all zero", fmt(o)); end
    o = sample(1);
    checks++;
    if (o !== obs_t'(0)) begin failures++; $display("FAIL reset_narrow got %s required all zero", fmt(o)); end
  endtask
  task automatic test_taken_br();
    stim_t t[$];
    obs_t e, o;
    do_reset();
    t.push_back(mk(0, 1, op_br, 3'b010, 3'b010, 16'h3000, 0, 1, 0, 16'h3000, 1, 1));
    t.push_back(mk(0, 1, op_br, 3'b111, 3'b111, 16'h4000, 0, 0, 0, 16'h3000, 1, 1));
    t.push_back(mk(0, 1, op_br, 3'b111, 3'b111, 16'h4000, 0, 0, 0, 16'h3000, 1, 1));
    t.push_back(mk(0, 1, op_br, 3'b111, 3'b111, 16'h4000, 0, 0, 0, 16'h3000, 1, 1));
    t.push_back(mk(0, 1, op_br, 3'b111, 3'b111, 16'h4000, 0, 1, 0, 16'h4000, 2, 2));
    foreach (t[i]) begin
      apply(t[i]);
      exp_q.push_back(t[i].e);
      tick();
      e = exp_q.pop_front();
      o = sample(0);
      checks++;
      if (o !== e) begin failures++; $display("FAIL taken_br step=%0d got %s required %s", i, fmt(o), fmt(e)); end
    end
  endtask
  task automatic test_not_taken();
    stim_t t[$];
    obs_t e, o;
    do_reset();
    t.push_back(mk(0, 1, op_br, 3'b111, 3'b111, 16'h1111, 1, 0, 0, 16'h0000, 0, 0));
    t.push_back(mk(0, 1, op_add, 3'b111, 3'b111, 16'h1111, 0, 0, 0, 16'h0000, 0, 0));
    t.push_back(mk(0, 1, op_br, 3'b100, 3'b001, 16'h1111, 0, 0, 0, 16'h0000, 1, 0));
    t.push_back(mk(0, 1, op_br, 3'b000, 3'b111, 16'h1111, 0, 0, 0, 16'h0000, 2, 0));
    t.push_back(mk(0, 1, op_br, 3'b111, 3'b000, 16'h1111, 0, 0, 0, 16'h0000, 3, 0));
    t.push_back(mk(0, 1, op_br, 3'b001, 3'b001, 16'h5555, 0, 1, 0, 16'h5555, 4, 1));
    foreach (t[i]) begin
      apply(t[i]);
      exp_q.push_back(t[i].e);
      tick();
      e = exp_q.pop_front();
      o = sample(0);
      checks++;
      if (o !== e) begin failures++; $display("FAIL not_taken step=%0d got %s required %s", i, fmt(o), fmt(e)); end
    end
  endtask
  task automatic test_stall_hold();
    stim_t t[$];
    obs_t e, o;
    do_reset();
    t.push_back(mk(0, 1, op_jsr, 3'b000, 3'b000, 16'h1234, 0, 0, 1, 16'h1234, 1, 1));
    for (int k = 0; k < 4; k++)
      t.push_back(mk(0, 1, op_jmp, 3'b000, 3'b000, 16'h5678, 1, 0, 1, 16'h1234, 1, 1));
    t.push_back(mk(0, 0, op_add, 3'b000, 3'b000, 16'h0000, 0, 0, 0, 16'h1234, 1, 1));
    t.push_back(mk(0, 0, op_add, 3'b000, 3'b000, 16'h0000, 0, 0, 0, 16'h1234, 1, 1));
    t.push_back(mk(0, 1, op_jmp, 3'b000, 3'b000, 16'h9999, 1, 0, 0, 16'h1234, 1, 1));
    t.push_back(mk(0, 1, op_jmp, 3'b000, 3'b000, 16'h9999, 0, 0, 0, 16'h1234, 1, 1));
    t.push_back(mk(0, 1, op_jmp, 3'b000, 3'b000, 16'h9999, 0, 0, 1, 16'h9999, 2, 2));
    foreach (t[i]) begin
      apply(t[i]);
      exp_q.push_back(t[i].e);
      tick();
      e = exp_q.pop_front();
      o = sample(0);
      checks++;
      if (o !== e) begin failures++; $display("FAIL stall_hold step=%0d got %s required %s", i, fmt(o), fmt(e)); end
    end
  endtask
  task automatic test_wrong_path();
    stim_t t[$];
    obs_t e, o;
    do_reset();
    t.push_back(mk(0, 1, op_br, 3'b100, 3'b100, 16'h2000, 0, 1, 0, 16'h2000, 1, 1));
    for (int k = 0; k < 3; k++)
      t.push_back(mk(0, 1, op_jmp, 3'b000, 3'b000, 16'h7777, 0, 0, 0, 16'h2000, 1, 1));
    t.push_back(mk(0, 1, op_jmp, 3'b000, 3'b000, 16'h7777, 0, 0, 1, 16'h7777, 2, 2));
    foreach (t[i]) begin
      apply(t[i]);
      exp_q.push_back(t[i].e);
      tick();
      e = exp_q.pop_front();
      o = sample(0);
      checks++;
      if (o !== e) begin failures++; $display("FAIL wrong_path step=%0d got %s required %s", i, fmt(o), fmt(e)); end
    end
  endtask
  task automatic test_reset_blackout();
    stim_t t[$];
    obs_t e, o;
    do_reset();
    t.push_back(mk(0, 1, op_jmp, 3'b000, 3'b000, 16'habcd, 0, 0, 1, 16'habcd, 1, 1));
    t.push_back(mk(0, 0, op_add, 3'b000, 3'b000, 16'h0000, 0, 0, 0, 16'habcd, 1, 1));
    t.push_back(mk(1, 1, op_jmp, 3'b000, 3'b000, 16'h5555, 0, 0, 0, 16'h0000, 0, 0));
    t.push_back(mk(0, 1, op_br, 3'b010, 3'b010, 16'h0042, 0, 1, 0, 16'h0042, 1, 1));
    foreach (t[i]) begin
      apply(t[i]);
      exp_q.push_back(t[i].e);
      tick();
      e = exp_q.pop_front();
      o = sample(0);
      checks++;
      if (o !== e) begin failures++; $display("FAIL reset_blackout step=%0d got %s required %s", i, fmt(o), fmt(e)); end
    end
  endtask
  task automatic test_saturation();
    stim_t t[$];
    obs_t e, o;
    logic [15:0] n;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      n = k < 15 ? 16'(k + 1) : 16'd15;
      t.push_back(mk(0, 1, op_trap, 3'b000, 3'b000, 16'(k), 0, 0, 1, 16'(k), n, n));
      for (int j = 0; j < 3; j++)
        t.push_back(mk(0, 0, op_add, 3'b000, 3'b000, 16'h0000, 0, 0, 0, 16'(k), n, n));
    end
    foreach (t[i]) begin
      apply(t[i]);
      exp_q.push_back(t[i].e);
      tick();
      e = exp_q.pop_front();
      o = sample(1);
      checks++;
      if (o !== e) begin failures++; $display("FAIL saturation step=%0d got %s required %s", i, fmt(o), fmt(e)); end
    end
    checks++;
    if (br_count !== 16'd20) begin failures++; $display("FAIL wide_count got %0d required 20", br_count); end
  endtask
  initial begin
    test_reset();
    test_taken_br();
    test_not_taken();
    test_stall_hold();
    test_wrong_path();
    test_reset_blackout();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
